// File: rtl/fifobuf_reader.sv
// fifobuf_reader: drains the read port of a fifobuffer and re-presents the
// words as a valid/ready stream at one word per clock. The FIFO's one-cycle
// read latency is absorbed by a 3-entry circular skid buffer. A transfer
// counter and a sticky error flag are also kept.
//
// Optional feature macro: FIFOBUF_READER_ERRCNT_EN adds an 8-bit saturating
// count of FIFO error cycles on port err_cnt.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   enable       1 = drain the FIFO, 0 = stop reading and flush in-flight data
//   fifo_oready  FIFO non-empty
//   fifo_odata   FIFO read data, valid the cycle after fifo_rden
//   fifo_err     FIFO error indication
//   fifo_rden    FIFO pop strobe (combinational, independent of m_ready)
//   m_data       stream data (skid buffer head)
//   m_valid      stream valid
//   m_ready      consumer accept
//   xfer_cnt     words accepted downstream, wraps modulo 2^CNT_W
//   err_sticky   latched FIFO error, set wins over err_clr
//   err_clr      clears err_sticky (and err_cnt when present)
//   err_cnt      [FIFOBUF_READER_ERRCNT_EN only] saturating error-cycle count
//   idle         high while the controller is in IDLE
module fifobuf_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_oready,
    input  logic [DATA_W-1:0] fifo_odata,
    input  logic              fifo_err,
    output logic              fifo_rden,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              err_sticky,
    input  logic              err_clr,
`ifdef FIFOBUF_READER_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              idle
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned OCC_W = 2;
    localparam int unsigned LVL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [OCC_W-1:0]  occ;
    logic              inflight;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic [LVL_W-1:0]  level;
    logic              push;
    logic              pop;

    // Wrap a buffer pointer 2 -> 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Words committed to the buffer: already stored plus the one arriving.
    assign level     = LVL_W'(occ) + LVL_W'(inflight);
    assign fifo_rden = (state == ST_RUN) && fifo_oready && (level < LVL_W'(DEPTH));
    assign m_valid   = (occ != '0);
    assign m_data    = buf_mem[head];
    assign idle      = (state == ST_IDLE);
    assign push      = inflight;
    assign pop       = m_valid && m_ready;

    // Controller state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (!inflight && (occ == '0)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Skid buffer: capture the word read last cycle, release the head on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= fifo_rden;
            if (push) begin
                buf_mem[tail] <= fifo_odata;
                tail          <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Transfer counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (fifo_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef FIFOBUF_READER_ERRCNT_EN
    // Saturating error-cycle count; a new error outranks a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (fifo_err) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fifobuf_reader.sv
// Testbench for fifobuf_reader: a queue-based FIFO feeds the design, and a
// reference model tracks words popped but not yet delivered, the stream order,
// controller idleness, transfer count and error flag. A second instance with a
// 4-bit counter shares all inputs to cover counter wrap-around.
module tb_fifobuf_reader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              fifo_oready;
    logic [DATA_W-1:0] fifo_odata;
    logic              fifo_err;
    logic              fifo_rden;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CNT_W-1:0]  xfer_cnt;
    logic              err_sticky;
    logic              err_clr;
    logic              idle;

    logic              fifo_rden4;
    logic [DATA_W-1:0] m_data4;
    logic              m_valid4;
    logic [3:0]        xfer_cnt4;
    logic              err_sticky4;
    logic              idle4;
`ifdef FIFOBUF_READER_ERRCNT_EN
    logic [7:0]        err_cnt;
    logic [7:0]        err_cnt4;
`endif

    fifobuf_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_oready(fifo_oready), .fifo_odata(fifo_odata), .fifo_err(fifo_err),
        .fifo_rden(fifo_rden), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .xfer_cnt(xfer_cnt), .err_sticky(err_sticky), .err_clr(err_clr),
`ifdef FIFOBUF_READER_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .idle(idle)
    );

    fifobuf_reader #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_oready(fifo_oready), .fifo_odata(fifo_odata), .fifo_err(fifo_err),
        .fifo_rden(fifo_rden4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .xfer_cnt(xfer_cnt4), .err_sticky(err_sticky4), .err_clr(err_clr),
`ifdef FIFOBUF_READER_ERRCNT_EN
        .err_cnt(err_cnt4),
`endif
        .idle(idle4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO contents and reference model state.
    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] exp_q[$];
    bit  run_m;
    bit  idle_m;
    bit  prev_rd_m;
    bit  err_m;
    int  outstanding;
    int  delivered;
    int  ecnt_m;
    int  n_cmp;
    int  n_fail;

    typedef struct {
        bit         en;
        bit         rdy;
        int         npush;
        logic [7:0] d0;
        bit         err;
        bit         clr;
        int         ncyc;
        int         exp_rd;
        int         exp_xfer;
        bit         exp_err;
        bit         exp_idle;
        int         exp_ecnt;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fq.push_back(w);
        fifo_oready = 1'b1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        run_m       = 1'b0;
        idle_m      = 1'b1;
        prev_rd_m   = 1'b0;
        err_m       = 1'b0;
        outstanding = 0;
        delivered   = 0;
        ecnt_m      = 0;
    endtask

    // One clock: compare outputs against the model, advance the model, then
    // let the FIFO answer any pop that the edge committed.
    task automatic cycle(output bit rd);
        bit exp_rd;
        bit exp_valid;
        int occ_m;
        int out_before;
        #2;
        occ_m     = outstanding - int'(prev_rd_m);
        exp_rd    = run_m && (fq.size() != 0) && (outstanding < 3);
        exp_valid = (occ_m > 0);
        check("fifo_rden", 32'(fifo_rden), 32'(exp_rd));
        check("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid && exp_q.size() != 0) begin
            check("m_data", 32'(m_data), 32'(exp_q[0]));
            check("m_data4", 32'(m_data4), 32'(exp_q[0]));
        end
        check("idle", 32'(idle), 32'(idle_m));
        check("xfer_cnt", 32'(xfer_cnt), 32'(delivered % 65536));
        check("xfer_cnt4", 32'(xfer_cnt4), 32'(delivered % 16));
        check("err_sticky", 32'(err_sticky), 32'(err_m));
        check("twin ctrl", 32'({fifo_rden4, m_valid4, idle4, err_sticky4}),
              32'({exp_rd, exp_valid, idle_m, err_m}));
`ifdef FIFOBUF_READER_ERRCNT_EN
        check("err_cnt", 32'(err_cnt), 32'(ecnt_m));
        check("err_cnt4", 32'(err_cnt4), 32'(ecnt_m));
`endif
        rd = fifo_rden;
        out_before = outstanding;
        if (exp_rd) begin
            exp_q.push_back(fq[0]);
            outstanding++;
        end
        if (exp_valid && m_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            delivered++;
            outstanding--;
        end
        idle_m    = !enable && (idle_m || (!run_m && out_before == 0));
        run_m     = enable;
        prev_rd_m = exp_rd;
        if (fifo_err) begin
            err_m  = 1'b1;
            ecnt_m = (ecnt_m < 255) ? ecnt_m + 1 : 255;
        end else if (err_clr) begin
            err_m  = 1'b0;
            ecnt_m = 0;
        end
        @(posedge clk);
        #1;
        if (rd && fq.size() != 0) fifo_odata = fq.pop_front();
        else                      fifo_odata = DATA_W'($urandom);
        fifo_oready = (fq.size() != 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst fifo_rden", 32'(fifo_rden), 32'(0));
        check("rst m_valid", 32'(m_valid), 32'(0));
        check("rst m_data", 32'(m_data), 32'(0));
        check("rst xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("rst err_sticky", 32'(err_sticky), 32'(0));
        check("rst idle", 32'(idle), 32'(1));
        enable   = 1'b0;
        m_ready  = 1'b0;
        fifo_err = 1'b0;
        err_clr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  rd;
        int  rd_cnt;
        bit  found;
        int  base;

        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        fifo_err = 1'b0;
        err_clr = 1'b0;
        fifo_oready = 1'b0;
        fifo_odata = '0;
        model_reset();

        //            en rdy np  d0    err clr cyc rd xfer err idle ecnt
        tbl[0] = '{1'b1, 1'b1, 3, 8'h11, 1'b0, 1'b0, 8, 3, 3, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 6, 8'h40, 1'b0, 1'b0, 10, 3, 3, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 10, 3, 9, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 0, 8'h00, 1'b1, 1'b0, 2, 0, 9, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b1, 0, 8'h00, 1'b1, 1'b1, 2, 0, 9, 1'b1, 1'b0, 2};
        tbl[5] = '{1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b1, 2, 0, 9, 1'b0, 1'b0, 0};
        tbl[6] = '{1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4, 0, 9, 1'b0, 1'b1, 0};
        tbl[7] = '{1'b0, 1'b1, 4, 8'hA0, 1'b0, 1'b0, 5, 0, 9, 1'b0, 1'b1, 0};

        #3;
        do_reset();

        for (int v = 0; v < 8; v++) begin
            rd_cnt   = 0;
            enable   = tbl[v].en;
            m_ready  = tbl[v].rdy;
            fifo_err = tbl[v].err;
            err_clr  = tbl[v].clr;
            for (int i = 0; i < tbl[v].npush; i++) begin
                push_word(DATA_W'(int'(tbl[v].d0) + i * 'h11));
            end
            for (int c = 0; c < tbl[v].ncyc; c++) begin
                cycle(rd);
                if (rd) rd_cnt++;
                fifo_err = 1'b0;
                err_clr  = 1'b0;
            end
            check($sformatf("vec%0d rden pulses", v), 32'(rd_cnt), 32'(tbl[v].exp_rd));
            check($sformatf("vec%0d xfer_cnt", v), 32'(xfer_cnt), 32'(tbl[v].exp_xfer));
            check($sformatf("vec%0d err_sticky", v), 32'(err_sticky), 32'(tbl[v].exp_err));
            check($sformatf("vec%0d idle", v), 32'(idle), 32'(tbl[v].exp_idle));
`ifdef FIFOBUF_READER_ERRCNT_EN
            check($sformatf("vec%0d err_cnt", v), 32'(err_cnt), 32'(tbl[v].exp_ecnt));
`endif
        end
        check("xfer_cnt4 after table", 32'(xfer_cnt4), 32'(9));

        // Enable drop one cycle after the first read of a burst.
        enable  = 1'b1;
        m_ready = 1'b1;
        found   = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle(rd);
            found = rd;
        end
        check("drop: first rden seen", 32'(found), 32'(1));
        enable = 1'b0;
        rd_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(rd);
            if (rd) rd_cnt++;
        end
        check("drop: rden after drop", 32'(rd_cnt), 32'(1));
        check("drop: fifo words kept", 32'(fq.size()), 32'(2));
        check("drop: xfer_cnt", 32'(xfer_cnt), 32'(11));
        check("drop: idle", 32'(idle), 32'(1));

        // Reset while two words sit in the buffer.
        for (int i = 0; i < 4; i++) push_word(DATA_W'(8'h01 + i));
        enable  = 1'b1;
        m_ready = 1'b0;
        found   = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle(rd);
            found = ((outstanding - int'(prev_rd_m)) == 2);
        end
        check("rst-mid: occ reached 2", 32'(found), 32'(1));
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) cycle(rd);
        check("rst-mid: xfer_cnt", 32'(xfer_cnt), 32'(3));
        check("rst-mid: fifo empty", 32'(fq.size()), 32'(0));

        // Randomized traffic against the reference model.
        base = 8'h80;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) enable = !enable;
            m_ready  = ($urandom_range(0, 3) != 0);
            fifo_err = ($urandom_range(0, 49) == 0);
            err_clr  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0 && fq.size() < 20) begin
                push_word(DATA_W'($urandom));
            end
            cycle(rd);
        end

        // Final drain: everything pushed must come out in order.
        enable   = 1'b1;
        m_ready  = 1'b1;
        fifo_err = 1'b0;
        err_clr  = 1'b0;
        for (int c = 0; c < 40; c++) cycle(rd);
        check("final: fifo empty", 32'(fq.size()), 32'(0));
        check("final: buffer empty", 32'(m_valid), 32'(0));
        check("final: nothing pending", 32'(exp_q.size()), 32'(0));
        check("final: xfer_cnt4 wraps", 32'(xfer_cnt4), 32'(delivered % 16));
        check("final: base unchanged", 32'(base), 32'(8'h80));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
